// File: rtl/motor_ramp.sv
// motor_ramp: limits duty slew per PWM period, ramps to zero, then holds a dead time before reversing.
module motor_ramp #(
  parameter int SIZE = 12,
  parameter int PERIOD = 4000,
  parameter int STEP = 100,
  parameter int DEAD_PERIODS = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [SIZE-1:0] target_duty,
  input  logic            target_dir,
  input  logic            period_done,
  output logic [SIZE-1:0] duty,
  output logic            dir,
  output logic            at_target,
  output logic            reversing
);
  localparam int DW = $clog2(DEAD_PERIODS) + 1;
  localparam logic [SIZE:0] PER = (SIZE+1)'(PERIOD);
  localparam logic [SIZE:0] STP = (SIZE+1)'(STEP);
  localparam logic [DW-1:0] LAST = DW'(DEAD_PERIODS - 1);
  typedef enum logic [1:0] {RUN, BRAKE, DEAD} state_t;
  state_t state, state_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [SIZE-1:0] duty_n;
  logic dir_n;
  logic [SIZE:0] cur, tgt, eff_tgt, goal, up, ramp;
  assign cur = {1'b0, duty};
  assign tgt = {1'b0, target_duty};
  assign eff_tgt = !enable ? '0 : (tgt > PER ? PER : tgt);
  // a pending reversal brakes toward zero regardless of the requested duty
  assign goal = (target_dir == dir) ? eff_tgt : '0;
  assign up = cur + STP;
  assign ramp = goal > cur ? (up > goal ? goal : up) : (cur > goal + STP ? cur - STP : goal);
  assign at_target = state == RUN && cur == eff_tgt && dir == target_dir;
  assign reversing = state == BRAKE || state == DEAD;
  always_comb begin
    state_n = state;
    duty_n = duty;
    dir_n = dir;
    dcnt_n = dcnt;
    if (state == DEAD) begin
      duty_n = '0;
      dcnt_n = dcnt == LAST ? '0 : dcnt + 1'b1;
      dir_n = dcnt == LAST ? target_dir : dir;
      state_n = dcnt == LAST ? RUN : DEAD;
    end else if (target_dir == dir || duty != '0) begin
      state_n = target_dir == dir ? RUN : BRAKE;
      duty_n = ramp[SIZE-1:0];
    end else begin
      state_n = DEAD;
      dcnt_n = '0;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
      duty <= '0;
      dir <= 1'b0;
      dcnt <= '0;
    end else if (period_done) begin
      state <= state_n;
      duty <= duty_n;
      dir <= dir_n;
      dcnt <= dcnt_n;
    end
  end
endmodule

// File: doc/motor_ramp.md
# motor_ramp

Soft-start / soft-reversal duty controller that sits directly upstream of the PWM generator on each rover drive channel. It accepts a requested speed (duty) and direction from the drive command logic and produces the `duty` and `dir` actually applied to the motor. `duty` moves by at most `STEP` counts per PWM period, paced by the PWM generator's end-of-period `done` pulse. A direction change always ramps to zero, then holds a dead time, before the new direction is applied.

## Interface
- `SIZE`, 12: width of duty values; must match the PWM generator.
- `PERIOD`, 4000: PWM period in counts; maximum legal duty. Must satisfy `PERIOD < 2^SIZE`.
- `STEP`, 100: maximum duty change per tick; range 1..`PERIOD`.
- `DEAD_PERIODS`, 4: ticks held at zero duty before a direction flip; minimum 1.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  when low, the effective target is forced to 0.
- `target_duty`  in  `SIZE`  requested duty.
- `target_dir`  in  1  requested direction (0 = forward, 1 = reverse).
- `period_done`  in  1  tick, driven by the PWM generator's `done` output.
- `duty`  out  `SIZE`  registered applied duty; feeds the PWM `duty` input.
- `dir`  out  1  registered applied direction; feeds the H-bridge.
- `at_target`  out  1  combinational; high when `state==RUN && duty==eff_tgt && dir==target_dir`.
- `reversing`  out  1  combinational; high when `state` is `BRAKE` or `DEAD`.

## Operation
- `eff_tgt` is 0 when `enable` is low. Otherwise it is `min(target_duty, PERIOD)`.
- All state changes happen only on a clock edge where `period_done` is high (a tick). Between ticks, every register holds.
- Inputs are sampled at the tick edge; there is no latching between ticks.
- The FSM has three states: `RUN`, `BRAKE`, `DEAD`. There is also a dead-time counter `dcnt` of width `clog2(DEAD_PERIODS)+1`.
- Ramp arithmetic is done at width `SIZE+1`, so there is no wrap-around.
  - Up: `duty <= min(duty+STEP, goal)`.
  - Down: `duty <= (duty > goal+STEP) ? duty-STEP : goal`.
- On a tick in `RUN` or `BRAKE`:
  - If `target_dir == dir`: state becomes `RUN`, and `duty` ramps toward `eff_tgt`. This includes cancelling an in-progress `BRAKE`.
  - If `target_dir != dir` and `duty > 0`: state becomes `BRAKE`, and `duty` ramps down toward 0. `eff_tgt` is ignored.
  - If `target_dir != dir` and `duty == 0`: state becomes `DEAD`, with `dcnt <= 0`. `duty` stays 0.
- On a tick in `DEAD`:
  - `duty` stays 0.
  - If `dcnt == DEAD_PERIODS-1`: `dir <= target_dir` (the value sampled at this tick), state becomes `RUN`, `dcnt <= 0`.
  - Otherwise, `dcnt` increments.
  - Dead time always completes, even if `target_dir` reverts during it.
- Invariants:
  - `duty` never exceeds `PERIOD`.
  - `dir` changes only on the `DEAD` exit tick, at which point `duty == 0`.

## Timing
- Reset (asynchronous, takes effect immediately): `duty=0`, `dir=0`, `state=RUN`, `dcnt=0`.
  - `reversing=0`.
  - `at_target` follows its equation, so it is 1 if `eff_tgt==0 && target_dir==0`.
- Latency: a target change is first reflected in `duty` at the first tick after it. Full-scale ramp time is `ceil(|Δ|/STEP)` ticks.
- Reversal from duty D:
  - `ceil(D/STEP)` ticks in `BRAKE`.
  - +1 tick (the tick where `duty==0` enters `DEAD`).
  - +`DEAD_PERIODS` ticks, after which `dir` flips.
  - The first nonzero new-direction duty appears on the following tick.
- Reversal from `duty==0`: the requesting tick enters `DEAD`; `dir` flips `DEAD_PERIODS` ticks later.
- `period_done` high on consecutive clocks counts as one tick per clock. The PWM generator guarantees a single-cycle pulse per period.
- `duty` changes only at a tick boundary, which is when the PWM counter restarts. There is no mid-period glitch.
- Reset asserted mid-ramp or mid-`DEAD`: outputs return to reset values asynchronously. On release, operation resumes from `RUN` with `duty=0`, `dir=0`.

## Test plan
- Reset, then `enable=1`, `target_duty=1000`, `target_dir=0`, one tick every 4001 clocks:
  - `duty` reads 100, 200, …, 1000 after ticks 1..10.
  - `at_target` rises after tick 10.
  - With no `period_done`, `duty` stays 0.
- `target_duty=4095` from `duty=0`:
  - `duty` saturates at exactly 4000 after 40 ticks and never exceeds it.
  - Then `target_duty=3950` gives `duty=3950` on the next tick.
- At `duty=250`, `dir=0`, set `target_dir=1`:
  - `duty` reads 150, 50, 0 (ticks 1-3, `reversing=1`); tick 4 enters `DEAD`.
  - `dir` flips to 1 at tick 8 with `duty=0`; tick 9 gives `duty=100`.
  - `dir` must never change while `duty != 0`.
- At `duty=250`, request reversal, then restore `target_dir=0` after tick 1 (`duty=150`): tick 2 returns to `RUN` with `duty=250`; `dir` stays 0.
- `enable` dropped at `duty=300`: `duty` reads 200, 100, 0 on successive ticks, with `dir` unchanged. Re-enabling restarts the ramp from 0.
- Assert `reset` between clock edges mid-`DEAD`: `duty=0`, `dir=0`, and `reversing=0` take effect before the next edge. After release, the ramp restarts from 0 in `RUN`.
